// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and debouncer.
package keypad_pkg;

    typedef enum logic {SCAN, LOCKED} scan_state_t;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    // Isolates the least-significant set bit, which is the highest-priority row.
    function automatic logic [3:0] onehot_lowest(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and index bundle; master is the scanner, slave is the pins/debouncer side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] keypad_rows;
    logic [NUM_COLS-1:0] keypad_cols;
    logic                key_pressed;
    logic [NUM_ROWS-1:0] row_idx;
    logic [NUM_COLS-1:0] col_idx;

    modport master (
        input  keypad_rows,
        output keypad_cols, key_pressed, row_idx, col_idx
    );

    modport slave (
        output keypad_rows,
        input  keypad_cols, key_pressed, row_idx, col_idx
    );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner that locks onto a pressed key and holds one-hot indices.
// Optional macro KEYPAD_GHOST_REJECT_EN: samples with more than one active row count as idle.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 3000
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kif
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    scan_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          ptr_q, ptr_d, ptr_inc;
    logic [NUM_COLS-1:0] cols_q, cols_d;
    logic                kp_q, kp_d;
    logic [NUM_ROWS-1:0] row_q, row_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic [NUM_ROWS-1:0] rows_sync, rows_act, rows_eff;
    logic                sample;

    sync_2ff #(.WIDTH(NUM_ROWS), .RESET_VAL(4'b1111)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (kif.keypad_rows),
        .q_o   (rows_sync)
    );

    assign rows_act = ~rows_sync;

`ifdef KEYPAD_GHOST_REJECT_EN
    // Clearing the lowest set bit leaves something only when two or more rows are active.
    assign rows_eff = ((rows_act & (rows_act - 4'd1)) != '0) ? '0 : rows_act;
`else
    assign rows_eff = rows_act;
`endif

    assign sample  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign cnt_d   = sample ? '0 : cnt_q + CNT_W'(1);
    assign ptr_inc = ptr_q + 2'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cols_d  = cols_q;
        kp_d    = kp_q;
        row_d   = row_q;
        col_d   = col_q;
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (rows_eff == '0) begin
                        ptr_d  = ptr_inc;
                        cols_d = ~(4'b0001 << ptr_inc);
                    end else begin
                        state_d = LOCKED;
                        kp_d    = 1'b1;
                        row_d   = onehot_lowest(rows_eff);
                        col_d   = 4'b0001 << ptr_q;
                    end
                end
                LOCKED: begin
                    if ((rows_eff & row_q) != '0) begin
                        row_d = row_q;
                    end else if (rows_eff != '0) begin
                        row_d = onehot_lowest(rows_eff);
                    end else begin
                        state_d = SCAN;
                        kp_d    = 1'b0;
                        row_d   = '0;
                        col_d   = '0;
                        ptr_d   = ptr_inc;
                        cols_d  = ~(4'b0001 << ptr_inc);
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            ptr_q   <= '0;
            cols_q  <= 4'b1110;
            kp_q    <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cols_q  <= cols_d;
            kp_q    <= kp_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign kif.keypad_cols = cols_q;
    assign kif.key_pressed = kp_q;
    assign kif.row_idx     = row_q;
    assign kif.col_idx     = col_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=8).
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] keys;          // bit r*4+c set: key at row r, column c is held down
    logic [3:0]  rows_model;

    always #5 clk = ~clk;

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    // A held key pulls its row low only while its column is driven low.
    always_comb begin
        rows_model = 4'b1111;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.keypad_cols[c]) rows_model[r] = 1'b0;
    end
    assign kif.keypad_rows = rows_model;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        string      name;
        logic [3:0] cols;
        logic       kp;
        logic [3:0] row;
        logic [3:0] col;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        string      name;
        logic [15:0] keys;
        logic       kp;
        logic [3:0] row;
        logic [3:0] col;
    } vec_t;

    task automatic push_exp(input string nm, input logic [3:0] cols, input logic kp,
                            input logic [3:0] row, input logic [3:0] col);
        exp_t e;
        e.name = nm; e.cols = cols; e.kp = kp; e.row = row; e.col = col;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        if (kif.keypad_cols !== e.cols || kif.key_pressed !== e.kp ||
            kif.row_idx !== e.row || kif.col_idx !== e.col) begin
            n_fail++;
            $display("FAIL %s: got cols=%b kp=%b row=%b col=%b, expected cols=%b kp=%b row=%b col=%b (t=%0t)",
                     e.name, kif.keypad_cols, kif.key_pressed, kif.row_idx, kif.col_idx,
                     e.cols, e.kp, e.row, e.col, $time);
        end
    endtask

    task automatic check_cond(input string nm, input logic ok, input int unsigned got,
                              input int unsigned want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic logic is_onehot(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    // Advance one clock and check the structural invariants away from the edge.
    task automatic tick();
        logic ok;
        @(posedge clk);
        @(negedge clk);
        ok = is_onehot(~kif.keypad_cols) &&
             (kif.key_pressed == (is_onehot(kif.row_idx) && is_onehot(kif.col_idx))) &&
             (!kif.key_pressed || (kif.col_idx == ~kif.keypad_cols)) &&
             (kif.key_pressed || (kif.row_idx == '0 && kif.col_idx == '0));
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL invariant: got cols=%b kp=%b row=%b col=%b (t=%0t)",
                     kif.keypad_cols, kif.key_pressed, kif.row_idx, kif.col_idx, $time);
        end
    endtask

    task automatic wait_kp(input logic val, input int unsigned budget, input string nm,
                           output int unsigned took);
        took = 0;
        while (kif.key_pressed !== val && took < budget) begin
            tick();
            took++;
        end
        check_cond(nm, kif.key_pressed === val, int'(kif.key_pressed), int'(val));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        int unsigned took;
        logic [3:0]  one;
        logic [3:0]  prev_cols;
        int unsigned seen, steps;
        logic        dropped;

        vecs[0] = '{"key_r3c3", 16'h8000, 1'b1, 4'b1000, 4'b1000};
        vecs[1] = '{"key_r2c1", 16'h0200, 1'b1, 4'b0100, 4'b0010};
        vecs[2] = '{"key_r0c3", 16'h0008, 1'b1, 4'b0001, 4'b1000};
        vecs[3] = '{"key_r1c0", 16'h0010, 1'b1, 4'b0010, 4'b0001};
`ifdef KEYPAD_GHOST_REJECT_EN
        vecs[4] = '{"multi_r0r2_c1", 16'h0202, 1'b0, 4'b0000, 4'b0000};
`else
        vecs[4] = '{"multi_r0r2_c1", 16'h0202, 1'b1, 4'b0001, 4'b0010};
`endif
        one  = 4'b0001;
        keys = '0;

        // Reset and idle scan: one column step per SCAN_DIV clocks.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        push_exp("reset", 4'b1110, 1'b0, 4'b0000, 4'b0000);
        check_out();
        rst_n = 1'b1;
        for (int unsigned k = 1; k <= 64; k++) begin
            push_exp("idle_scan", ~(one << ((k / SCAN_DIV) % 4)), 1'b0, 4'b0000, 4'b0000);
            tick();
            check_out();
        end

        // Key '1' (row 0, column 0): lock within one scan period, column frozen.
        keys = 16'h0001;
        wait_kp(1'b1, 4*SCAN_DIV + 4, "t2_lock_timeout", took);
        check_cond("t2_lock_latency", took <= 4*SCAN_DIV + 2, took, 4*SCAN_DIV + 2);
        push_exp("t2_key1", 4'b1110, 1'b1, 4'b0001, 4'b0001);
        check_out();
        for (int unsigned i = 0; i < 10; i++) begin
            repeat (10) tick();
            push_exp("t2_frozen", 4'b1110, 1'b1, 4'b0001, 4'b0001);
            check_out();
        end
        keys = '0;
        wait_kp(1'b0, SCAN_DIV + 4, "t2_release_timeout", took);

        // Row 1 / column 2 held for 40 clocks, then released.
        keys = 16'h0040;
        wait_kp(1'b1, 4*SCAN_DIV + 4, "t3_lock_timeout", took);
        for (int unsigned i = 0; i < 40; i++) begin
            push_exp("t3_held", 4'b1011, 1'b1, 4'b0010, 4'b0100);
            tick();
            check_out();
        end
        keys = '0;
        wait_kp(1'b0, SCAN_DIV + 4, "t3_release_timeout", took);
        check_cond("t3_release_latency", took >= 3 && took <= SCAN_DIV + 2, took, SCAN_DIV + 2);
        push_exp("t3_released", 4'b0111, 1'b0, 4'b0000, 4'b0000);
        check_out();

        // Single keys and a two-row press in one column.
        for (int unsigned v = 0; v < 5; v++) begin
            keys = vecs[v].keys;
            if (vecs[v].kp) begin
                wait_kp(1'b1, 4*SCAN_DIV + 4, {vecs[v].name, "_timeout"}, took);
                push_exp(vecs[v].name, ~vecs[v].col, 1'b1, vecs[v].row, vecs[v].col);
                check_out();
            end else begin
                seen = 0;
                steps = 0;
                prev_cols = kif.keypad_cols;
                repeat (5*SCAN_DIV) begin
                    tick();
                    if (kif.key_pressed) seen++;
                    if (kif.keypad_cols != prev_cols) steps++;
                    prev_cols = kif.keypad_cols;
                end
                check_cond({vecs[v].name, "_no_press"}, seen == 0, seen, 0);
                check_cond({vecs[v].name, "_scan_steps"}, steps >= 4, steps, 4);
            end
            keys = '0;
            wait_kp(1'b0, SCAN_DIV + 4, {vecs[v].name, "_release_timeout"}, took);
        end

        // Locked on row 0: row 0 releases while row 3 goes low in the same column.
        keys = 16'h0001;
        wait_kp(1'b1, 4*SCAN_DIV + 4, "t5_lock_timeout", took);
        push_exp("t5_locked", 4'b1110, 1'b1, 4'b0001, 4'b0001);
        check_out();
        keys = 16'h1000;
        took = 0;
        dropped = 1'b0;
        while (kif.row_idx === 4'b0001 && took < SCAN_DIV + 4) begin
            tick();
            took++;
            if (!kif.key_pressed) dropped = 1'b1;
        end
        check_cond("t5_kp_held", !dropped, int'(dropped), 0);
        check_cond("t5_switch_latency", took >= 3 && took <= SCAN_DIV + 2, took, SCAN_DIV + 2);
        push_exp("t5_row_switch", 4'b1110, 1'b1, 4'b1000, 4'b0001);
        check_out();
        keys = '0;
        wait_kp(1'b0, SCAN_DIV + 4, "t5_release_timeout", took);

        // Reset mid-dwell while locked, then the scan restarts from column 0.
        keys = 16'h0004;
        wait_kp(1'b1, 4*SCAN_DIV + 4, "t6_lock_timeout", took);
        push_exp("t6_locked", 4'b1011, 1'b1, 4'b0001, 4'b0100);
        check_out();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        push_exp("t6_async_reset", 4'b1110, 1'b0, 4'b0000, 4'b0000);
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned k = 1; k <= 3*SCAN_DIV; k++) begin
            tick();
            if (k == SCAN_DIV - 1) begin
                push_exp("t6_col0_hold", 4'b1110, 1'b0, 4'b0000, 4'b0000); check_out();
            end else if (k == SCAN_DIV) begin
                push_exp("t6_col1", 4'b1101, 1'b0, 4'b0000, 4'b0000); check_out();
            end else if (k == 2*SCAN_DIV) begin
                push_exp("t6_col2", 4'b1011, 1'b0, 4'b0000, 4'b0000); check_out();
            end else if (k == 3*SCAN_DIV - 1) begin
                push_exp("t6_prelock", 4'b1011, 1'b0, 4'b0000, 4'b0000); check_out();
            end else if (k == 3*SCAN_DIV) begin
                push_exp("t6_relock", 4'b1011, 1'b1, 4'b0001, 4'b0100); check_out();
            end
        end
        keys = '0;
        wait_kp(1'b0, SCAN_DIV + 4, "t6_release_timeout", took);

        check_cond("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
